// File: rtl/osc_scan_ctrl_pkg.sv
// Shared types and widths for the combinational-loop oscillation scanner.
package osc_scan_ctrl_pkg;

    localparam int VEC_W   = 8;
    localparam int PROBE_W = 3;
    localparam int CNT_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_OBSERVE = 3'd3,
        ST_EVAL    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/osc_scan_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous probe/flag nets.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/osc_scan_ctrl.sv
// Walks all 256 input vectors, settles, watches loop feedback nets for
// transitions, and tallies oscillations and flag disagreements.
module osc_scan_ctrl
    import osc_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int OBS_CYC    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [VEC_W-1:0]   vec_out,
    input  logic [PROBE_W-1:0] loop_probe,
    input  logic               osc_flag_in,
    output logic               busy,
    output logic               done,
    output logic               sample_valid,
    output logic [VEC_W-1:0]   sample_vec,
    output logic               sample_osc,
    output logic [CNT_W-1:0]   osc_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [VEC_W-1:0]   first_osc_vec,
    output logic               first_osc_valid,
    output logic [2:0]         dbg_state
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       OBS_LAST    = 8'(OBS_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [VEC_W-1:0] VEC_ONE     = VEC_W'(1);
    localparam logic [VEC_W-1:0] VEC_LAST    = '1;

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [PROBE_W-1:0]   prev_q, prev_d;
    logic                 obs_q, obs_d;
    logic [CNT_W-1:0]     osc_cnt_q, osc_cnt_d;
    logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;
    logic [VEC_W-1:0]     first_vec_q, first_vec_d;
    logic                 first_valid_q, first_valid_d;

    logic [PROBE_W:0]     sync_s;
    logic [PROBE_W-1:0]   probe_s;
    logic                 flag_s;

    sync2 #(.W(PROBE_W + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({osc_flag_in, loop_probe}),
        .q_o   (sync_s)
    );

    assign flag_s  = sync_s[PROBE_W];
    assign probe_s = sync_s[PROBE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            cnt_q         <= '0;
            prev_q        <= '0;
            obs_q         <= 1'b0;
            osc_cnt_q     <= '0;
            mis_cnt_q     <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            obs_q         <= obs_d;
            osc_cnt_q     <= osc_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
            first_vec_q   <= first_vec_d;
            first_valid_q <= first_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        obs_d         = obs_q;
        osc_cnt_d     = osc_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        first_vec_d   = first_vec_q;
        first_valid_d = first_valid_q;
        // Abort overrides everything, including start in IDLE and a pending EVAL.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        vec_d         = '0;
                        osc_cnt_d     = '0;
                        mis_cnt_d     = '0;
                        first_vec_d   = '0;
                        first_valid_d = 1'b0;
                        state_d       = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    obs_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        prev_d  = probe_s;
                        state_d = ST_OBSERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_OBSERVE: begin
                    if (probe_s != prev_q) obs_d = 1'b1;
                    prev_d = probe_s;
                    if (cnt_q == OBS_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_EVAL: begin
                    if (obs_q) osc_cnt_d = osc_cnt_q + CNT_ONE;
                    if (flag_s != obs_q) mis_cnt_d = mis_cnt_q + CNT_ONE;
                    if (obs_q && !first_valid_q) begin
                        first_vec_d   = vec_q;
                        first_valid_d = 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        state_d = ST_APPLY;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign vec_out         = vec_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign sample_valid    = (state_q == ST_EVAL);
    assign sample_vec      = vec_q;
    assign sample_osc      = sample_valid & obs_q;
    assign osc_cnt         = osc_cnt_q;
    assign mismatch_cnt    = mis_cnt_q;
    assign first_osc_vec   = first_vec_q;
    assign first_osc_valid = first_valid_q;
    assign dbg_state       = state_q;

endmodule
